// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage MIPS core.
// Generates the PC / IF_ID / ID_EX / EX_MEM enables and flushes from
// load-use hazards, taken branches, data-memory wait and mult/div occupancy.
// Also owns the mult/div busy FSM and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int MD_LATENCY = 32,  // cycles the mult/div unit stays busy (2..63)
  parameter int CNT_W      = 16   // width of stall_cycles
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_use_rs,
  input  logic             ID_use_rt,
  input  logic             ID_md_start,
  input  logic             ID_md_read,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_rt,
  input  logic             EX_branch_taken,
  input  logic             mem_stall,
  output logic             pc_en,
  output logic             IF_ID_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_en,
  output logic             ID_EX_flush,
  output logic             EX_MEM_en,
  output logic             md_issue,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t   state, next_state;
  logic [5:0]  cnt, next_cnt;
  logic        lu, mh, go_md, hazard_stall;

  // Hazard detection: a load writing $0 never creates a dependency.
  always_comb begin
    lu = EX_MemRead && (EX_rt != 5'd0) &&
         ((ID_use_rs && (ID_rs == EX_rt)) || (ID_use_rt && (ID_rt == EX_rt)));
    mh = md_busy && (ID_md_start || ID_md_read);
    go_md = !rst && (state == IDLE) && ID_md_start && !lu &&
            !EX_branch_taken && !mem_stall;
    // A counted stall is the plain hazard case only: freeze and squash win.
    hazard_stall = !rst && !mem_stall && !EX_branch_taken && (lu || mh);
  end

  // Mult/div FSM state register; reset abandons any operation in flight.
  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here would create ordering-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Mult/div next state: the counter runs every cycle, even under mem_stall.
  // NOTE: every signal assigned here gets a default first, otherwise a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    unique case (state)
      IDLE: begin
        if (go_md) begin
          next_state = BUSY;
          next_cnt   = 6'(MD_LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt == 6'd0) next_state = IDLE;
        else             next_cnt   = cnt - 6'd1;
      end
      default: next_state = IDLE;
    endcase
  end

  // Pipeline control outputs, in priority order: reset, freeze, squash, stall.
  always_comb begin
    pc_en       = 1'b1;
    IF_ID_en    = 1'b1;
    IF_ID_flush = 1'b0;
    ID_EX_en    = 1'b1;
    ID_EX_flush = 1'b0;
    EX_MEM_en   = 1'b1;
    md_issue    = 1'b0;
    md_busy     = !rst && (state == BUSY);
    if (rst) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (mem_stall) begin
      pc_en     = 1'b0;
      IF_ID_en  = 1'b0;
      ID_EX_en  = 1'b0;
      EX_MEM_en = 1'b0;
    end else if (EX_branch_taken) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (lu || mh) begin
      pc_en       = 1'b0;
      IF_ID_en    = 1'b0;
      ID_EX_flush = 1'b1;
    end else begin
      md_issue = go_md;
    end
  end

  // Saturating count of hazard stall cycles; holds at all-ones.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= '0;
    else if (hazard_stall && (stall_cycles != {CNT_W{1'b1}}))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl (MD_LATENCY=4, CNT_W=4).
// The driver applies one input vector per cycle, predicts the outputs from a
// cycle-level behavioural model and queues them; a monitor compares on negedge.
module tb_hazard_ctrl;

  localparam int L  = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    ID_rs, ID_rt, EX_rt;
  logic          ID_use_rs, ID_use_rt, ID_md_start, ID_md_read;
  logic          EX_MemRead, EX_branch_taken, mem_stall;
  logic          pc_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush, EX_MEM_en;
  logic          md_issue, md_busy;
  logic [CW-1:0] stall_cycles;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs, rt, ex_rt;
    logic       use_rs, use_rt, md_start, md_read, memread, br, mstall;
  } stim_t;

  typedef struct packed {
    logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en;
    logic          md_issue, md_busy;
    logic [CW-1:0] stall;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   done     = 1'b0;

  // Behavioural model: remaining busy cycles and the stall total.
  int busy_left = 0;
  int stall_tot = 0;

  hazard_ctrl #(.MD_LATENCY(L), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt),
    .ID_md_start(ID_md_start), .ID_md_read(ID_md_read),
    .EX_MemRead(EX_MemRead), .EX_rt(EX_rt), .EX_branch_taken(EX_branch_taken),
    .mem_stall(mem_stall),
    .pc_en(pc_en), .IF_ID_en(IF_ID_en), .IF_ID_flush(IF_ID_flush),
    .ID_EX_en(ID_EX_en), .ID_EX_flush(ID_EX_flush), .EX_MEM_en(EX_MEM_en),
    .md_issue(md_issue), .md_busy(md_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
  endtask

  // Apply one cycle of stimulus, predict outputs, advance the model.
  task automatic step(input stim_t s);
    exp_t e;
    bit   busy, lu, mh, stall;
    rst = s.rst; ID_rs = s.rs; ID_rt = s.rt; EX_rt = s.ex_rt;
    ID_use_rs = s.use_rs; ID_use_rt = s.use_rt;
    ID_md_start = s.md_start; ID_md_read = s.md_read;
    EX_MemRead = s.memread; EX_branch_taken = s.br; mem_stall = s.mstall;

    busy = (busy_left > 0);
    lu   = s.memread && s.ex_rt != 0 &&
           ((s.use_rs && s.rs == s.ex_rt) || (s.use_rt && s.rt == s.ex_rt));
    mh   = busy && (s.md_start || s.md_read);
    e = '{pc_en:1, if_id_en:1, if_id_flush:0, id_ex_en:1, id_ex_flush:0,
          ex_mem_en:1, md_issue:0, md_busy:(!s.rst && busy), stall:CW'(stall_tot)};
    stall = 1'b0;
    if (s.rst) begin
      e.if_id_flush = 1; e.id_ex_flush = 1;
    end else if (s.mstall) begin
      e.pc_en = 0; e.if_id_en = 0; e.id_ex_en = 0; e.ex_mem_en = 0;
    end else if (s.br) begin
      e.if_id_flush = 1; e.id_ex_flush = 1;
    end else if (lu || mh) begin
      e.pc_en = 0; e.if_id_en = 0; e.id_ex_flush = 1; stall = 1'b1;
    end else begin
      e.md_issue = !busy && s.md_start;
    end
    exp_q.push_back(e);

    if (s.rst) begin
      busy_left = 0; stall_tot = 0;
    end else begin
      if (e.md_issue)         busy_left = L;
      else if (busy_left > 0) busy_left--;
      if (stall && stall_tot < CMAX) stall_tot++;
    end
    @(posedge clk); #1;
  endtask

  // Monitor: compare whenever an expected vector is waiting.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc_en",        pc_en,        e.pc_en);
        check("IF_ID_en",     IF_ID_en,     e.if_id_en);
        check("IF_ID_flush",  IF_ID_flush,  e.if_id_flush);
        check("ID_EX_en",     ID_EX_en,     e.id_ex_en);
        check("ID_EX_flush",  ID_EX_flush,  e.id_ex_flush);
        check("EX_MEM_en",    EX_MEM_en,    e.ex_mem_en);
        check("md_issue",     md_issue,     e.md_issue);
        check("md_busy",      md_busy,      e.md_busy);
        check("stall_cycles", stall_cycles, e.stall);
      end
    end
  end

  function automatic stim_t idle_stim();
    stim_t s = '0;
    s.rs = 5'd1; s.rt = 5'd2; s.ex_rt = 5'd3;
    return s;
  endfunction

  initial begin
    stim_t s;
    s = idle_stim(); s.rst = 1;
    rst = 1; ID_rs = 0; ID_rt = 0; EX_rt = 0; ID_use_rs = 0; ID_use_rt = 0;
    ID_md_start = 0; ID_md_read = 0; EX_MemRead = 0; EX_branch_taken = 0;
    mem_stall = 0;
    @(posedge clk); #1;

    // Reset held two cycles, then a quiet cycle.
    step(s); step(s);
    step(idle_stim());

    // Load-use on rs, then the same pattern with EX_rt == 0.
    s = idle_stim(); s.memread = 1; s.ex_rt = 5; s.rs = 5; s.use_rs = 1;
    step(s);
    step(idle_stim());
    s.ex_rt = 0; s.rs = 0;
    step(s);
    // Load-use on rt.
    s = idle_stim(); s.memread = 1; s.ex_rt = 7; s.rt = 7; s.use_rt = 1;
    step(s);

    // Mult issue, then an mfhi held in ID until it proceeds.
    s = idle_stim(); s.md_start = 1; step(s);
    s = idle_stim(); s.md_read = 1;
    for (int i = 0; i < L + 1; i++) step(s);

    // Branch over simultaneous load-use and mult start.
    s = idle_stim(); s.br = 1; s.md_start = 1; s.memread = 1; s.ex_rt = 4;
    s.rs = 4; s.use_rs = 1;
    step(s);

    // Freeze while busy: issue, one busy cycle, then 3 mem_stall cycles.
    s = idle_stim(); s.md_start = 1; step(s);
    step(idle_stim());
    s = idle_stim(); s.mstall = 1; s.md_read = 1;
    for (int i = 0; i < 3; i++) step(s);
    for (int i = 0; i < 3; i++) step(idle_stim());

    // Back-to-back mult/div: second start stalls until IDLE.
    s = idle_stim(); s.md_start = 1;
    for (int i = 0; i < L + 3; i++) step(s);
    for (int i = 0; i < L; i++) step(idle_stim());

    // Saturation: 20 load-use stalls.
    s = idle_stim(); s.memread = 1; s.ex_rt = 9; s.rt = 9; s.use_rt = 1;
    for (int i = 0; i < 20; i++) step(s);
    step(idle_stim());

    // Reset mid-operation.
    s = idle_stim(); s.md_start = 1; step(s);
    step(idle_stim());
    s = idle_stim(); s.rst = 1; step(s);
    s = idle_stim(); s.md_read = 1; step(s);

    // Randomised traffic with small register numbers to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      s = '0;
      s.rst      = ($urandom_range(0, 59) == 0);
      s.rs       = 5'($urandom_range(0, 3));
      s.rt       = 5'($urandom_range(0, 3));
      s.ex_rt    = 5'($urandom_range(0, 3));
      s.use_rs   = 1'($urandom_range(0, 1));
      s.use_rt   = 1'($urandom_range(0, 1));
      s.memread  = ($urandom_range(0, 2) == 0);
      s.md_start = ($urandom_range(0, 3) == 0);
      s.md_read  = ($urandom_range(0, 3) == 0);
      s.br       = ($urandom_range(0, 5) == 0);
      s.mstall   = ($urandom_range(0, 5) == 0);
      step(s);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Generates enable/flush for PC, IF_ID, ID_EX and EX_MEM from load-use hazards, taken branches, data-memory wait and the multi-cycle mult/div unit occupancy.
- Owns the mult/div busy FSM and a saturating stall-cycle performance counter.
- Sits beside the ID stage. All pipeline registers are driven only through its enables and flushes.

Parameters:
- MD_LATENCY, 32, cycles the mult/div unit is occupied after issue (legal range 2..63).
- CNT_W, 16, width of stall_cycles counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- ID_rs  in  5  rs field of instruction in ID.
- ID_rt  in  5  rt field of instruction in ID.
- ID_use_rs  in  1  ID instruction reads rs.
- ID_use_rt  in  1  ID instruction reads rt.
- ID_md_start  in  1  ID instruction is mult/multu/div/divu.
- ID_md_read  in  1  ID instruction is mfhi/mflo.
- EX_MemRead  in  1  EX instruction is a load.
- EX_rt  in  5  destination register of EX load.
- EX_branch_taken  in  1  branch/jump resolved taken in EX.
- mem_stall  in  1  data memory not ready this cycle.
- pc_en  out  1  PC update enable.
- IF_ID_en  out  1  IF_ID write enable.
- IF_ID_flush  out  1  IF_ID loads NOP.
- ID_EX_en  out  1  ID_EX write enable.
- ID_EX_flush  out  1  ID_EX loads bubble (RegWrite=0).
- EX_MEM_en  out  1  EX_MEM write enable.
- md_issue  out  1  one-cycle start pulse to mult/div unit.
- md_busy  out  1  mult/div unit occupied.
- stall_cycles  out  CNT_W  saturating count of hazard stall cycles.

Behaviour:
- All enable/flush outputs are combinational from inputs and registered state. state, cnt and stall_cycles are registered.
- Clock and reset:
  - One clock: clk.
  - Reset is synchronous and active-high: rst.
- While rst=1:
  - pc_en=1, IF_ID_en=1, ID_EX_en=1, EX_MEM_en=1.
  - IF_ID_flush=1, ID_EX_flush=1.
  - md_issue=0, md_busy=0.
- At the clock edge with rst=1: state<=IDLE, cnt<=0, stall_cycles<=0. Reset mid-mult/div abandons the operation.
- Load-use hazard: lu = EX_MemRead && EX_rt!=0 && ((ID_use_rs && ID_rs==EX_rt) || (ID_use_rt && ID_rt==EX_rt)).
- Mult/div hazard: mh = md_busy && (ID_md_start || ID_md_read).
- FSM states:
  - IDLE: md_busy=0. If go_md, then state<=BUSY and cnt<=MD_LATENCY-1.
  - BUSY: md_busy=1. cnt decrements every cycle, independent of mem_stall.
  - BUSY with cnt==0: next state IDLE. That final BUSY cycle still counts as busy, so an mfhi in ID proceeds the following cycle.
- go_md = state==IDLE && ID_md_start && !lu && !EX_branch_taken && !mem_stall. md_issue = go_md.
- Priority, highest first:
  1. mem_stall=1: all four enables 0, flushes 0, md_issue 0 (freeze).
  2. EX_branch_taken=1: all enables 1, IF_ID_flush=1, ID_EX_flush=1. The ID instruction is squashed, so no issue occurs and no hazard stall is counted.
  3. lu or mh: pc_en=0, IF_ID_en=0, ID_EX_en=1, ID_EX_flush=1, EX_MEM_en=1.
  4. Otherwise: all enables 1, flushes 0.
- stall_cycles increments by 1 on each non-reset cycle where case 3 applies. It saturates at all-ones and never wraps. Freeze and flush cycles are not counted.
- Simultaneous md_start in ID and BUSY with cnt==0: the instruction stalls one cycle and issues the next cycle from IDLE.
- Back-to-back mult/div: the second one stalls until IDLE and issues in its first IDLE cycle.
- lu with EX_rt==0 never stalls.

Test Plan:
- Reset: hold rst 2 cycles -> both flushes=1 during reset. After release: md_busy=0, stall_cycles=0, all enables=1, flushes=0.
- Load-use: EX_MemRead=1, EX_rt=5, ID_rs=5, ID_use_rs=1 -> pc_en=0, IF_ID_en=0, ID_EX_flush=1, stall_cycles=1 after the edge. Same with EX_rt=0 -> no stall.
- Mult/div (MD_LATENCY=4): ID_md_start=1 in IDLE -> md_issue=1 for 1 cycle, md_busy=1 for exactly 4 cycles. An mfhi held in ID stalls those 4 cycles and proceeds on cycle 5. stall_cycles=4.
- Branch over hazard: EX_branch_taken=1 together with lu=1 and ID_md_start=1 -> IF_ID_flush=1, ID_EX_flush=1, pc_en=1, md_issue=0, stall_cycles unchanged.
- Memory freeze: mem_stall=1 for 3 cycles during BUSY with cnt=2 -> all enables 0, no flush. md_busy drops after 2 more cycles (counter not frozen), stall_cycles unchanged.
- Saturation (CNT_W=4): force 20 load-use stall cycles -> stall_cycles=15, stays 15.
